mem_demo_sequencer: RTL and testbench
=====================================

// Module: mem_demo_sequencer
// PURPOSE
//   Read-modify-write sequencer for the lab3 block-RAM demo datapath.
//   A press of the active-low start button walks NUM_WORDS consecutive addresses
//   from BASE_ADDR. For each address it reads the word, adds INCR and writes the
//   result back. The last written value is held for the 4-digit hex display.
//   It sits between the board button and the single-port synchronous BRAM.
//   The display decoders (hex3..hex0) consume disp_value.
// PARAMETERS
//   DATA_WIDTH  16  BRAM word width; disp_value width
//   ADDR_WIDTH  10  BRAM address width
//   NUM_WORDS   4   words processed per run (1..2**ADDR_WIDTH)
//   BASE_ADDR   0   first address of a run
//   INCR        1   value added to each word, modulo 2**DATA_WIDTH
// PORTS
//   clk           in   1           system clock, all logic on rising edge
//   reset         in   1           asynchronous reset, active-high
//   start_button  in   1           raw push-button, active-low, asynchronous to clk
//   mem_addr      out  ADDR_WIDTH  BRAM address
//   mem_we        out  1           BRAM write enable
//   mem_wdata     out  DATA_WIDTH  BRAM write data
//   mem_rdata     in   DATA_WIDTH  BRAM read data, valid 1 cycle after mem_addr
//   disp_value    out  DATA_WIDTH  last value written, drives hex display
//   busy          out  1           high while a run is in progress
//   done          out  1           one-cycle pulse when a run completes
// BEHAVIOUR
//   - Clock and reset: one clock. reset is asynchronous and active-high and is
//     named as the codebase does.
//   - Outputs are registered. On reset, all outputs go to 0.
//   - Start button: start_button passes through a 2-FF synchronizer. A falling
//     edge of the synchronized signal gives a one-cycle start pulse.
//     * Holding the button gives exactly one pulse.
//     * A pulse that arrives while busy is ignored. It is not queued.
//   - FSM states and transitions:
//     IDLE -> RD (on start) -> WT -> WR -> RD (more words) | DONE -> IDLE.
//   - Per state:
//     * IDLE: mem_we=0.
//     * RD: mem_addr=current address, mem_we=0.
//     * WT: wait for BRAM read latency.
//     * WR: mem_we=1, mem_wdata=mem_rdata+INCR (truncated to DATA_WIDTH, so
//       0xFFFF+1 gives 0x0000). disp_value takes the same value on the same edge.
//     * DONE: done=1 for one cycle, busy=0 from the next cycle.
//   - Timing:
//     * 3 cycles per word. busy is high for exactly 3*NUM_WORDS+1 cycles
//       (RD..DONE).
//     * Start pulse to first RD: 1 cycle.
//     * Button fall to busy: at most 4 clk edges.
//   - Address counter: reloads BASE_ADDR at each start and increments after each
//     WR. It wraps modulo 2**ADDR_WIDTH.
//   - disp_value holds between runs. done is never high outside DONE.
//     mem_we is high only in WR.
//   - Reset mid-run: the FSM returns to IDLE asynchronously and mem_we drops
//     immediately. Words already written keep their new values; the rest are
//     untouched. No resume.
// STRUCTURE
//   - Package lab3_pkg:
//     * FSM state localparams (IDLE, RD, WT, WR, DONE; 3-bit encoding)
//     * default DATA_WIDTH and ADDR_WIDTH
//   - Sub-module button_edge_sync: 2-FF synchronizer plus falling-edge detector,
//     output start_pulse. It also resets on reset.
//   - The top holds the FSM, address/word counters and output registers.
// TESTING
//   Bench BRAM model: 1-cycle read latency. Clock period 10 ns.
//   1. Reset asserted -> mem_addr=0, mem_we=0, mem_wdata=0, disp_value=0,
//      busy=0, done=0.
//   2. Preload mem[0..3]=0000,00FF,1234,FFFF, then press the button
//      -> mem becomes 0001,0100,1235,0000. disp_value=0000. busy high 13 cycles.
//      One done pulse.
//   3. Press again during run (busy=1) -> ignored. Press after done
//      -> mem becomes 0002,0101,1236,0001 and disp_value=0001.
//   4. Hold start_button low for 1000 ns -> exactly one run (4 mem_we pulses),
//      no second start.
//   5. Assert reset during WR of word 2 -> busy=0 and mem_we=0 immediately.
//      Words 0 and 1 are updated; words 2 and 3 are unchanged.
//   6. BASE_ADDR=1022, ADDR_WIDTH=10, NUM_WORDS=4 -> writes hit addresses
//      1022, 1023, 0, 1 in order.

Source files
------------

// File: rtl/lab3_pkg.sv
// Shared types and default widths for the lab3 block-RAM demo datapath.
package lab3_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_ADDR_WIDTH = 10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WT   = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/button_edge_sync.sv
// Brings the raw active-low push-button into the clk domain and emits a
// single-cycle pulse on each press (falling edge of the synchronized level).
module button_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic button_n,
    output logic start_pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = button_n;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Flops reset to the released (high) level so leaving reset never looks like a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign start_pulse = prev_q & ~sync2_q;

endmodule

// File: rtl/mem_demo_sequencer.sv
// Read-modify-write sequencer: on each button press, adds INCR to NUM_WORDS
// consecutive BRAM words starting at BASE_ADDR and latches the last result.
module mem_demo_sequencer
    import lab3_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int NUM_WORDS  = 4,
    parameter int BASE_ADDR  = 0,
    parameter int INCR       = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_button,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] disp_value,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [DATA_WIDTH-1:0] INC      = DATA_WIDTH'(INCR);

    logic start_pulse;

    button_edge_sync u_button_edge_sync (
        .clk         (clk),
        .reset       (reset),
        .button_n    (start_button),
        .start_pulse (start_pulse)
    );

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [ADDR_WIDTH-1:0] idx_q,   idx_d;
    logic                  we_q,    we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] disp_q,  disp_d;
    logic                  busy_q,  busy_d;
    logic                  done_q,  done_d;

    // Outputs are decided from the next state so they are registered yet aligned with it.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        we_d    = 1'b0;
        wdata_d = wdata_q;
        disp_d  = disp_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_pulse) begin
                    state_d = RD;
                    addr_d  = BASE;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            RD: state_d = WT;
            WT: begin
                state_d = WR;
                we_d    = 1'b1;
                wdata_d = mem_rdata + INC;
                disp_d  = mem_rdata + INC;
            end
            WR: begin
                addr_d = addr_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = RD;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            disp_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            disp_q  <= disp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign mem_addr   = addr_q;
    assign mem_we     = we_q;
    assign mem_wdata  = wdata_q;
    assign disp_value = disp_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_mem_demo_sequencer.sv
// Directed bench: default sequencer plus a second instance based at 1022 to
// exercise address wrap; each has its own 1-cycle-latency BRAM model.
module tb_mem_demo_sequencer;

    logic        clk;
    logic        rst;
    logic        btn1, btn2;
    logic [9:0]  addr1, addr2;
    logic        we1, we2;
    logic [15:0] wdata1, wdata2, rdata1, rdata2, disp1, disp2;
    logic        busy1, busy2, done1, done2;

    logic [15:0] mem1 [0:1023];
    logic [15:0] mem2 [0:1023];

    logic [25:0] exp_q [$];
    logic [25:0] exp2_q [$];

    int checks = 0;
    int errors = 0;
    int busy_cycles = 0;
    int we_count = 0;
    int done_count = 0;

    mem_demo_sequencer dut (
        .clk(clk), .reset(rst), .start_button(btn1),
        .mem_addr(addr1), .mem_we(we1), .mem_wdata(wdata1), .mem_rdata(rdata1),
        .disp_value(disp1), .busy(busy1), .done(done1)
    );

    mem_demo_sequencer #(.BASE_ADDR(1022)) dut_wrap (
        .clk(clk), .reset(rst), .start_button(btn2),
        .mem_addr(addr2), .mem_we(we2), .mem_wdata(wdata2), .mem_rdata(rdata2),
        .disp_value(disp2), .busy(busy2), .done(done2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM models
    always @(posedge clk) begin
        if (we1) mem1[addr1] <= wdata1;
        rdata1 <= mem1[addr1];
        if (we2) mem2[addr2] <= wdata2;
        rdata2 <= mem2[addr2];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every write must match the head of the expected queue
    always @(negedge clk) begin
        logic [25:0] e;
        if (busy1) busy_cycles++;
        if (done1) done_count++;
        if (we1) begin
            we_count++;
            if (exp_q.size() == 0) check("wr_extra", 32'(exp_q.size()), 32'd1);
            else begin
                e = exp_q.pop_front();
                check("wr_addr_data", {6'd0, addr1, wdata1}, {6'd0, e});
            end
        end
        if (we2) begin
            if (exp2_q.size() == 0) check("wrap_wr_extra", 32'(exp2_q.size()), 32'd1);
            else begin
                e = exp2_q.pop_front();
                check("wrap_wr_addr_data", {6'd0, addr2, wdata2}, {6'd0, e});
            end
        end
    end

    // driver tasks
    task automatic press(input bit which, input int cycles);
        @(posedge clk); #1;
        if (which) btn2 = 1'b0; else btn1 = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        if (which) btn2 = 1'b1; else btn1 = 1'b1;
    endtask

    task automatic wait_done(input bit which, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if ((which ? done2 : done1) === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic clear_counts();
        @(posedge clk); #1;
        busy_cycles = 0;
        we_count = 0;
        done_count = 0;
    endtask

    task automatic check_mem1(input string tag, input logic [15:0] v0, input logic [15:0] v1,
                              input logic [15:0] v2, input logic [15:0] v3);
        check({tag, "_m0"}, 32'(mem1[0]), 32'(v0));
        check({tag, "_m1"}, 32'(mem1[1]), 32'(v1));
        check({tag, "_m2"}, 32'(mem1[2]), 32'(v2));
        check({tag, "_m3"}, 32'(mem1[3]), 32'(v3));
    endtask

    task automatic push_exp(input logic [9:0] a, input logic [15:0] d);
        exp_q.push_back({a, d});
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        btn1 = 1'b1;
        btn2 = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            mem1[i] = 16'h0;
            mem2[i] = 16'h0;
        end

        // 1. reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_addr", 32'(addr1), 32'd0);
        check("rst_we", 32'(we1), 32'd0);
        check("rst_wdata", 32'(wdata1), 32'd0);
        check("rst_disp", 32'(disp1), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 2/3. first run with a second press while busy
        mem1[0] = 16'h0000; mem1[1] = 16'h00FF; mem1[2] = 16'h1234; mem1[3] = 16'hFFFF;
        push_exp(10'd0, 16'h0001); push_exp(10'd1, 16'h0100);
        push_exp(10'd2, 16'h1235); push_exp(10'd3, 16'h0000);
        clear_counts();
        press(1'b0, 3);
        repeat (3) @(posedge clk);
        check("t3_busy_at_repress", 32'(busy1), 32'd1);
        press(1'b0, 2);
        wait_done(1'b0, 60, seen);
        check("t2_done_seen", 32'(seen), 32'd1);
        repeat (15) @(posedge clk);
        #1;
        check_mem1("t2", 16'h0001, 16'h0100, 16'h1235, 16'h0000);
        check("t2_disp", 32'(disp1), 32'h0000);
        check("t2_busy_cycles", 32'(busy_cycles), 32'd13);
        check("t2_done_pulses", 32'(done_count), 32'd1);
        check("t3_writes_one_run", 32'(we_count), 32'd4);
        check("t2_sb_drained", 32'(exp_q.size()), 32'd0);

        // 3. press after done
        push_exp(10'd0, 16'h0002); push_exp(10'd1, 16'h0101);
        push_exp(10'd2, 16'h1236); push_exp(10'd3, 16'h0001);
        clear_counts();
        press(1'b0, 3);
        wait_done(1'b0, 60, seen);
        check("t3_done_seen", 32'(seen), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check_mem1("t3", 16'h0002, 16'h0101, 16'h1236, 16'h0001);
        check("t3_disp", 32'(disp1), 32'h0001);
        check("t3_busy_after", 32'(busy1), 32'd0);

        // 4. button held for 1000 ns
        push_exp(10'd0, 16'h0003); push_exp(10'd1, 16'h0102);
        push_exp(10'd2, 16'h1237); push_exp(10'd3, 16'h0002);
        clear_counts();
        press(1'b0, 100);
        repeat (20) @(posedge clk);
        #1;
        check("t4_we_pulses", 32'(we_count), 32'd4);
        check("t4_done_pulses", 32'(done_count), 32'd1);
        check("t4_busy_cycles", 32'(busy_cycles), 32'd13);
        check("t4_disp", 32'(disp1), 32'h0002);

        // 5. reset during WR of word 2
        push_exp(10'd0, 16'h0004); push_exp(10'd1, 16'h0103); push_exp(10'd2, 16'h1238);
        press(1'b0, 3);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (we1 === 1'b1 && addr1 === 10'd2) seen = 1'b1;
        end
        check("t5_reached_wr2", 32'(seen), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t5_busy_drop", 32'(busy1), 32'd0);
        check("t5_we_drop", 32'(we1), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_mem1("t5", 16'h0004, 16'h0103, 16'h1237, 16'h0002);
        check("t5_sb_drained", 32'(exp_q.size()), 32'd0);

        // 6. address wrap from 1022
        mem2[1022] = 16'h0010; mem2[1023] = 16'hABCD; mem2[0] = 16'h7FFF; mem2[1] = 16'hFFFF;
        exp2_q.push_back({10'd1022, 16'h0011});
        exp2_q.push_back({10'd1023, 16'hABCE});
        exp2_q.push_back({10'd0, 16'h8000});
        exp2_q.push_back({10'd1, 16'h0000});
        press(1'b1, 3);
        wait_done(1'b1, 60, seen);
        check("t6_done_seen", 32'(seen), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("t6_m1022", 32'(mem2[1022]), 32'h0011);
        check("t6_m1023", 32'(mem2[1023]), 32'hABCE);
        check("t6_m0", 32'(mem2[0]), 32'h8000);
        check("t6_m1", 32'(mem2[1]), 32'h0000);
        check("t6_disp", 32'(disp2), 32'h0000);
        check("t6_sb_drained", 32'(exp2_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
